// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch front end for the 16-bit stack processor. It holds the
// program counter, issues byte addresses to instruction memory over a req/ack
// handshake and advances by 2 for each accepted 16-bit instruction. Each fetched
// instruction is tagged with its own address and handed to the decoder through
// a single-entry valid/ready buffer. A branch request redirects the PC without
// withdrawing or altering a request that memory has not yet acknowledged.
//
// Ports
//   CLK            in   rising-edge clock
//   RST_n          in   asynchronous active-low reset
//   imem_req       out  fetch request, held until imem_ack
//   imem_addr      out  byte address of the requested instruction (= pc)
//   imem_ack       in   memory accepts the request, imem_rdata valid this cycle
//   imem_rdata     in   instruction word
//   branch_en      in   one-cycle redirect strobe
//   branch_target  in   redirect address (bit 0 ignored)
//   instr_valid    out  instr/instr_pc hold a live instruction
//   instr          out  buffered instruction word
//   instr_pc       out  address the buffered instruction was fetched from
//   instr_ready    in   decoder consumes when instr_valid & instr_ready
//   pc             out  current fetch PC
//
// All outputs come from registers or are decoded from the state register, so
// there is no combinational path from any input to any output.
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        CLK,
  input  logic        RST_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  input  logic        branch_en,
  input  logic [15:0] branch_target,
  output logic        instr_valid,
  output logic [15:0] instr,
  output logic [15:0] instr_pc,
  input  logic        instr_ready,
  output logic [15:0] pc
);

  // Instructions are halfword aligned, so bit 0 of any fetch address is zero.
  localparam logic [15:0] LP_RESET_PC = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3   // request outstanding whose data must be thrown away
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc;
  logic [15:0] r_pending;
  logic [15:0] r_instr;
  logic [15:0] r_instr_pc;
  logic        r_instr_valid;

  state_t      w_state_nxt;
  logic [15:0] w_pc_nxt;
  logic [15:0] w_pending_nxt;
  logic [15:0] w_instr_nxt;
  logic [15:0] w_instr_pc_nxt;
  logic        w_instr_valid_nxt;
  logic [15:0] w_target;

  assign w_target = branch_target & 16'hFFFE;

  // NOTE: state uses non-blocking assignments so every register samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= IDLE;
      r_pc          <= LP_RESET_PC;
      r_pending     <= 16'h0000;
      r_instr       <= 16'h0000;
      r_instr_pc    <= 16'h0000;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_pending     <= w_pending_nxt;
      r_instr       <= w_instr_nxt;
      r_instr_pc    <= w_instr_pc_nxt;
      r_instr_valid <= w_instr_valid_nxt;
    end
  end

  // NOTE: every signal is given its hold value before the case statement, so
  // no path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt       = r_state;
    w_pc_nxt          = r_pc;
    w_pending_nxt     = r_pending;
    w_instr_nxt       = r_instr;
    w_instr_pc_nxt    = r_instr_pc;
    w_instr_valid_nxt = r_instr_valid;

    case (r_state)
      IDLE: begin
        if (branch_en) w_pc_nxt = w_target;
        w_state_nxt = FETCH;
      end

      FETCH: begin
        if (branch_en && imem_ack) begin
          // Fetched word belongs to the old stream; reissue at the target.
          w_pc_nxt = w_target;
        end else if (branch_en) begin
          // The request is already on the bus and must complete unchanged;
          // remember where to go once it is acknowledged.
          w_pending_nxt = w_target;
          w_state_nxt   = FLUSH;
        end else if (imem_ack) begin
          w_instr_nxt       = imem_rdata;
          w_instr_pc_nxt    = r_pc;
          w_instr_valid_nxt = 1'b1;
          w_pc_nxt          = r_pc + 16'd2;  // wraps modulo 2^16
          w_state_nxt       = HOLD;
        end
      end

      FLUSH: begin
        if (imem_ack) begin
          // A branch arriving with the ack is newer than the pending one.
          w_pc_nxt    = branch_en ? w_target : r_pending;
          w_state_nxt = FETCH;
        end else if (branch_en) begin
          w_pending_nxt = w_target;
        end
      end

      HOLD: begin
        // Branch wins over consumption: the buffered instruction is on the
        // wrong path and is dropped even if the decoder is ready.
        if (branch_en) begin
          w_instr_valid_nxt = 1'b0;
          w_pc_nxt          = w_target;
          w_state_nxt       = FETCH;
        end else if (r_instr_valid && instr_ready) begin
          w_instr_valid_nxt = 1'b0;
          w_state_nxt       = FETCH;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign imem_req    = (r_state == FETCH) || (r_state == FLUSH);
  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit (RESET_PC = 128). A transaction-level
// reference model tracks whether the unit is idle, whether the decoder buffer
// is full, and whether the outstanding memory request is being discarded in
// favour of a queued redirect. Directed steps cover the reset, streaming,
// wrap-around, wait-state, redirect-while-waiting, branch-over-ready and
// mid-handshake reset cases; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

  localparam logic [15:0] RST_PC = 16'd128;

  logic        CLK;
  logic        RST_n;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        branch_en;
  logic [15:0] branch_target;
  logic        instr_valid;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_ready;
  logic [15:0] pc;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  bit          m_idle;     // first cycle after reset, no request yet
  bit          m_full;     // decoder buffer holds a live instruction
  bit          m_discard;  // outstanding request's data will be thrown away
  logic [15:0] m_pc;
  logic [15:0] m_redir;
  logic [15:0] m_instr;
  logic [15:0] m_instr_pc;

  instr_fetch_unit #(.RESET_PC(RST_PC)) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .branch_en     (branch_en),
    .branch_target (branch_target),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .instr_ready   (instr_ready),
    .pc            (pc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_idle     = 1'b1;
    m_full     = 1'b0;
    m_discard  = 1'b0;
    m_pc       = RST_PC;
    m_redir    = 16'h0000;
    m_instr    = 16'h0000;
    m_instr_pc = 16'h0000;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_update();
    logic [15:0] tgt;
    tgt = branch_target & 16'hFFFE;
    if (m_idle) begin
      if (branch_en) m_pc = tgt;
      m_idle = 1'b0;
    end else if (m_full) begin
      if (branch_en) begin
        m_full = 1'b0;
        m_pc   = tgt;
      end else if (instr_ready) begin
        m_full = 1'b0;
      end
    end else if (imem_ack) begin
      if (m_discard) begin
        m_pc      = branch_en ? tgt : m_redir;
        m_discard = 1'b0;
      end else if (branch_en) begin
        m_pc = tgt;
      end else begin
        m_instr    = imem_rdata;
        m_instr_pc = m_pc;
        m_full     = 1'b1;
        m_pc       = m_pc + 16'd2;
      end
    end else if (branch_en) begin
      m_discard = 1'b1;
      m_redir   = tgt;
    end
  endtask

  task automatic compare_all(input string where);
    logic m_req;
    m_req = !m_idle && !m_full;
    check({where, ".imem_req"},    {15'b0, imem_req},    {15'b0, m_req});
    check({where, ".imem_addr"},   imem_addr,            m_pc);
    check({where, ".pc"},          pc,                   m_pc);
    check({where, ".instr_valid"}, {15'b0, instr_valid}, {15'b0, m_full});
    check({where, ".instr"},       instr,                m_instr);
    check({where, ".instr_pc"},    instr_pc,             m_instr_pc);
  endtask

  // One clock with the currently driven inputs; outputs sampled 1 ns later.
  task automatic step(input string where);
    model_update();
    @(posedge CLK);
    #1;
    compare_all(where);
  endtask

  task automatic drive(input logic be, input logic [15:0] bt, input logic ack,
                       input logic [15:0] rd, input logic rdy);
    branch_en     = be;
    branch_target = bt;
    imem_ack      = ack;
    imem_rdata    = rd;
    instr_ready   = rdy;
  endtask

  initial begin
    RST_n = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    model_reset();

    // ---- Reset values ----
    #2 RST_n = 1'b0;
    @(posedge CLK); #1;
    compare_all("reset");
    RST_n = 1'b1;
    compare_all("post_reset_idle");  // no request in the first cycle

    // ---- Zero-wait streaming from 128 ----
    drive(1'b0, 16'h0000, 1'b1, 16'hA001, 1'b1);
    step("stream_c1");
    check("stream_first_addr", imem_addr, 16'd128);
    step("stream_c2");
    check("stream_instr_pc0", instr_pc, 16'd128);
    check("stream_instr0", instr, 16'hA001);
    check("stream_next_addr", imem_addr, 16'd130);
    step("stream_c3");
    step("stream_c4");
    check("stream_instr_pc1", instr_pc, 16'd130);
    step("stream_c5");
    step("stream_c6");
    check("stream_instr_pc2", instr_pc, 16'd132);

    // ---- Branch to 0xFFFE from HOLD, PC wraps to 0 ----
    drive(1'b1, 16'hFFFE, 1'b1, 16'hB002, 1'b1);
    step("wrap_branch");
    check("wrap_valid_drop", {15'b0, instr_valid}, 16'h0000);
    check("wrap_target_addr", imem_addr, 16'hFFFE);
    drive(1'b0, 16'h0000, 1'b1, 16'hB003, 1'b1);
    step("wrap_fetch");
    check("wrap_instr_pc", instr_pc, 16'hFFFE);
    check("wrap_next_addr", imem_addr, 16'h0000);

    // ---- Ack delayed 3 cycles at 0x0010 ----
    drive(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b1);
    step("wait_branch");
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("wait_stall");
      check("wait_addr_stable", imem_addr, 16'h0010);
      check("wait_req_high", {15'b0, imem_req}, 16'h0001);
    end
    drive(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0);
    check("wait_req_ack_cycle", {15'b0, imem_req}, 16'h0001);
    step("wait_ack");
    check("wait_valid_rise", {15'b0, instr_valid}, 16'h0001);
    check("wait_instr_pc", instr_pc, 16'h0010);
    check("wait_instr", instr, 16'h1234);

    // ---- Branch while waiting: data 0xDEAD discarded ----
    drive(1'b1, 16'h0010, 1'b0, 16'h0000, 1'b0);
    step("flush_setup");
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0);
    step("flush_wait0");
    drive(1'b1, 16'h0200, 1'b0, 16'h0000, 1'b0);
    step("flush_branch");
    check("flush_addr_held", imem_addr, 16'h0010);
    drive(1'b0, 16'h0000, 1'b0, 16'hDEAD, 1'b0);
    step("flush_wait1");
    drive(1'b0, 16'h0000, 1'b1, 16'hDEAD, 1'b0);
    step("flush_ack");
    check("flush_no_dead", {15'b0, instr == 16'hDEAD}, 16'h0000);
    check("flush_next_addr", imem_addr, 16'h0200);
    drive(1'b0, 16'h0000, 1'b1, 16'h5555, 1'b0);
    step("flush_refetch");
    check("flush_refetch_pc", instr_pc, 16'h0200);

    // ---- Branch beats instr_ready in HOLD, odd target aligned ----
    drive(1'b1, 16'h0041, 1'b0, 16'h0000, 1'b1);
    step("hold_branch");
    check("hold_valid_low", {15'b0, instr_valid}, 16'h0000);
    check("hold_branch_addr", imem_addr, 16'h0040);

    // ---- Reset asserted during a FETCH wait ----
    drive(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1);
    step("rst_wait");
    #2 RST_n = 1'b0;
    #1;
    model_reset();
    check("rst_req_now", {15'b0, imem_req}, 16'h0000);
    check("rst_valid_now", {15'b0, instr_valid}, 16'h0000);
    compare_all("rst_mid");
    @(posedge CLK); #1;
    compare_all("rst_held");
    RST_n = 1'b1;
    compare_all("rst_release_idle");
    step("rst_first_req");
    check("rst_first_addr", imem_addr, RST_PC);
    check("rst_first_req_hi", {15'b0, imem_req}, 16'h0001);

    // ---- Randomized traffic ----
    for (int i = 0; i < 600; i++) begin
      logic [15:0] bt;
      bt = ($urandom_range(0, 3) == 0) ? 16'hFFFC + 16'($urandom_range(0, 3))
                                        : 16'($urandom);
      drive(($urandom_range(0, 7) == 0), bt, 1'($urandom_range(0, 1)),
            16'($urandom), ($urandom_range(0, 9) < 6));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
